// File: rtl/fu_exec_unit_pkg.sv
// Shared definitions for the execution functional unit: opcodes, FSM states
// and default widths.
package fu_exec_unit_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int TAG_W_DEF  = 4;
    localparam int NO_TAG     = 0;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_OR  = 2'b10;
    localparam logic [1:0] OP_MUL = 2'b11;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        EXEC     = 2'd1,
        WAIT_CDB = 2'd2
    } fu_state_t;

endpackage

// File: rtl/fu_exec_unit_alu_core.sv
// Purely combinational arithmetic core; all results wrap modulo 2^DATA_W.
module fu_alu_core
    import fu_exec_unit_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] result
);

    always_comb begin
        result = '0;
        unique case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_OR:   result = a | b;
            OP_MUL:  result = a * b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/fu_exec_unit.sv
// Single-issue functional unit: latches an op from the reservation station,
// counts its latency, then holds the result until the CDB arbiter grants it.
module fu_exec_unit
    import fu_exec_unit_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TAG_W   = TAG_W_DEF,
    parameter int LAT_ALU = 1,
    parameter int LAT_MUL = 3,
    parameter int CNT_W   = 3
) (
    input  logic              clk,
    input  logic              nRST,
    input  logic              issue_valid,
    input  logic [1:0]        issue_op,
    input  logic [DATA_W-1:0] issue_a,
    input  logic [DATA_W-1:0] issue_b,
    input  logic [TAG_W-1:0]  issue_label,
    output logic              exe_ready,
    input  logic              cdb_grant,
    output logic              cdb_req,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_label,
    output logic [DATA_W-1:0] cdb_data,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_ALU = CNT_W'(LAT_ALU - 1);
    localparam logic [CNT_W-1:0] CNT_MUL = CNT_W'(LAT_MUL - 1);

    fu_state_t         state, state_n;
    logic [CNT_W-1:0]  cnt;
    logic [1:0]        op_q;
    logic [DATA_W-1:0] a_q, b_q, result_q, alu_out;
    logic [TAG_W-1:0]  label_q;
    logic              accept;

    fu_alu_core #(.DATA_W(DATA_W)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_out)
    );

    // A grant while waiting frees the unit in the same cycle, so the station
    // can hand over the next op without a bubble.
    assign cdb_req   = (state == WAIT_CDB);
    assign cdb_valid = cdb_req & cdb_grant;
    assign exe_ready = (state == IDLE) | cdb_valid;
    assign accept    = issue_valid & exe_ready;
    assign busy      = (state != IDLE);
    assign cdb_label = cdb_req ? label_q : '0;
    assign cdb_data  = cdb_req ? result_q : '0;

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:     if (accept) state_n = EXEC;
            EXEC:     if (cnt == '0) state_n = WAIT_CDB;
            WAIT_CDB: begin
                if (accept)
                    state_n = EXEC;
                else if (cdb_grant)
                    state_n = IDLE;
            end
            default:  state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            cnt      <= '0;
            op_q     <= OP_ADD;
            a_q      <= '0;
            b_q      <= '0;
            label_q  <= '0;
            result_q <= '0;
        end else if (accept) begin
            op_q    <= issue_op;
            a_q     <= issue_a;
            b_q     <= issue_b;
            label_q <= issue_label;
            cnt     <= (issue_op == OP_MUL) ? CNT_MUL : CNT_ALU;
        end else if (state == EXEC) begin
            if (cnt == '0)
                result_q <= alu_out;
            else
                cnt <= cnt - 1'b1;
        end
    end

endmodule
